pwm_speed_ctrl: RTL and testbench



---
 rtl/pwm_speed_ctrl_if.sv | 21 ++
 rtl/pwm_speed_ctrl.sv | 139 +++++++++++++
 tb/tb_pwm_speed_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_speed_ctrl_if.sv
// Operator-side signal bundle for pwm_speed_ctrl: run flag and switches in,
// PWM waveform, level and 7-segment digit out.
interface pwm_speed_ctrl_if;
  logic       run_en;
  logic       inc_sw;
  logic       dec_sw;
  logic       pwm_out;
  logic [3:0] level;
  logic       period_start;
  logic [6:0] seg_n;

  modport master (
    output run_en, inc_sw, dec_sw,
    input  pwm_out, level, period_start, seg_n
  );

  modport slave (
    input  run_en, inc_sw, dec_sw,
    output pwm_out, level, period_start, seg_n
  );
endinterface

// File: rtl/pwm_speed_ctrl.sv
// Motor speed level holder and PWM generator; duty follows the level, latched per period.
// Optional active-low 7-segment level digit enabled by defining SEG7_DISPLAY_EN.
module pwm_speed_ctrl #(
  parameter int PRESC_DIV   = 50,
  parameter int LEVEL_MAX   = 9,
  parameter int LEVEL_START = 5
) (
  input  logic             clk,
  input  logic             rst,
  pwm_speed_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int              PW         = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [3:0]      LMAX       = 4'(LEVEL_MAX);
  localparam logic [3:0]      LSTART     = 4'(LEVEL_START);

  state_t        state;
  logic [3:0]    level_q;
  logic [3:0]    duty_act;
  logic [3:0]    pwm_cnt;
  logic [PW-1:0] presc;
  logic          pwm_q;
  logic          ps_q;
  logic          inc_s1, inc_s2, inc_prev;
  logic          dec_s1, dec_s2, dec_prev;
  logic          inc_edge, dec_edge;

  // Switches are asynchronous: two-flop synchronizer, then one step per press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_s1   <= 1'b0;
      inc_s2   <= 1'b0;
      inc_prev <= 1'b0;
      dec_s1   <= 1'b0;
      dec_s2   <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      inc_s1   <= bus.inc_sw;
      inc_s2   <= inc_s1;
      inc_prev <= inc_s2;
      dec_s1   <= bus.dec_sw;
      dec_s2   <= dec_s1;
      dec_prev <= dec_s2;
    end
  end

  assign inc_edge = inc_s2 & ~inc_prev;
  assign dec_edge = dec_s2 & ~dec_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      level_q  <= 4'd0;
      duty_act <= 4'd0;
      pwm_cnt  <= 4'd0;
      presc    <= '0;
      pwm_q    <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      ps_q  <= 1'b0;
      pwm_q <= (state == RUN) && (pwm_cnt < duty_act);
      case (state)
        IDLE: begin
          if (bus.run_en) begin
            state    <= RUN;
            level_q  <= LSTART;
            duty_act <= LSTART;
            pwm_cnt  <= 4'd0;
            presc    <= '0;
          end
        end
        RUN: begin
          if (!bus.run_en) begin
            state    <= IDLE;
            level_q  <= 4'd0;
            duty_act <= 4'd0;
            pwm_cnt  <= 4'd0;
            presc    <= '0;
          end else begin
            // Duty is only reloaded at the period wrap so no runt pulses appear.
            if (presc == PRESC_LAST) begin
              presc <= '0;
              if (pwm_cnt == LMAX) begin
                pwm_cnt  <= 4'd0;
                duty_act <= level_q;
                ps_q     <= 1'b1;
              end else begin
                pwm_cnt <= pwm_cnt + 4'd1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
            if (inc_edge && !dec_edge && (level_q != LMAX))
              level_q <= level_q + 4'd1;
            else if (dec_edge && !inc_edge && (level_q != 4'd0))
              level_q <= level_q - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.level        = level_q;
  assign bus.period_start = ps_q;

`ifdef SEG7_DISPLAY_EN
  logic [6:0] seg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_q <= 7'b1000000;
    end else begin
      case (level_q)
        4'd0:    seg_q <= 7'b1000000;
        4'd1:    seg_q <= 7'b1111001;
        4'd2:    seg_q <= 7'b0100100;
        4'd3:    seg_q <= 7'b0110000;
        4'd4:    seg_q <= 7'b0011001;
        4'd5:    seg_q <= 7'b0010010;
        4'd6:    seg_q <= 7'b0000010;
        4'd7:    seg_q <= 7'b1111000;
        4'd8:    seg_q <= 7'b0000000;
        4'd9:    seg_q <= 7'b0010000;
        default: seg_q <= 7'b1111111;
      endcase
    end
  end

  assign bus.seg_n = seg_q;
`else
  assign bus.seg_n = 7'b1111111;
`endif

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Randomized self-checking bench for pwm_speed_ctrl against a time-based reference model
// (PWM position derived from clocks elapsed since RUN entry).
module tb_pwm_speed_ctrl;

  localparam int P    = 2;
  localparam int LMAX = 9;
  localparam int LST  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_speed_ctrl_if bus ();

  pwm_speed_ctrl #(.PRESC_DIV(P), .LEVEL_MAX(LMAX), .LEVEL_START(LST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit         m_run;
  int         m_level;
  int         m_duty;
  int         m_j;
  bit         m_pwm;
  bit         m_ps;
  logic [6:0] m_seg;
  bit [2:0]   hi;
  bit [2:0]   hd;

  function automatic logic [6:0] seg_of(input int lv);
`ifdef SEG7_DISPLAY_EN
    case (lv)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
`else
    return (lv >= 0) ? 7'b1111111 : 7'b1111111;
`endif
  endfunction

  task automatic m_reset();
    m_run   = 1'b0;
    m_level = 0;
    m_duty  = 0;
    m_j     = 0;
    m_pwm   = 1'b0;
    m_ps    = 1'b0;
    m_seg   = seg_of(0);
    hi      = '0;
    hd      = '0;
  endtask

  // Advance one clock and evolve the model from the pre-edge state and inputs.
  task automatic cycle();
    bit ie, de;
    @(posedge clk);
    if (rst) begin
      ie    = hi[1] & ~hi[2];
      de    = hd[1] & ~hd[2];
      hi    = {hi[1:0], bus.inc_sw};
      hd    = {hd[1:0], bus.dec_sw};
      m_pwm = m_run && (((m_j / P) % (LMAX + 1)) < m_duty);
      m_seg = seg_of(m_level);
      m_ps  = 1'b0;
      if (!m_run) begin
        if (bus.run_en) begin
          m_run = 1'b1; m_level = LST; m_duty = LST; m_j = 0;
        end
      end else if (!bus.run_en) begin
        m_run = 1'b0; m_level = 0; m_duty = 0; m_j = 0;
      end else begin
        m_j++;
        if (m_j % (P * (LMAX + 1)) == 0) begin
          m_ps   = 1'b1;
          m_duty = m_level;
        end
        if (ie && !de)      m_level = (m_level < LMAX) ? m_level + 1 : LMAX;
        else if (de && !ie) m_level = (m_level > 0) ? m_level - 1 : 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    bus.run_en = 1'b0;
    bus.inc_sw = 1'b0;
    bus.dec_sw = 1'b0;
    rst = 1'b0;
    m_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cycle();
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {1'b0, 4'd0, 1'b0, seg_of(0)}) begin
        failures++;
        $display("[TB] FAIL reset i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {1'b0, 4'd0, 1'b0, seg_of(0)});
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_start();
    int high = 0;
    bus.run_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (i >= 1 && i <= 20 && bus.pwm_out === 1'b1) high++;
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {m_pwm, 4'(m_level), m_ps, m_seg}) begin
        failures++;
        $display("[TB] FAIL start i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {m_pwm, 4'(m_level), m_ps, m_seg});
      end
    end
    checks++;
    if (high != 10) begin
      failures++;
      $display("[TB] FAIL start_high_time got=%0d exp=10", high);
    end
  endtask

  task automatic test_inc_hold();
    bus.inc_sw = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {m_pwm, 4'(m_level), m_ps, m_seg}) begin
        failures++;
        $display("[TB] FAIL inc_hold i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {m_pwm, 4'(m_level), m_ps, m_seg});
      end
      if (i < 3) begin
        checks++;
        if (bus.level !== ((i == 2) ? 4'd6 : 4'd5)) begin
          failures++;
          $display("[TB] FAIL inc_latency i=%0d got=%0d exp=%0d", i, bus.level, (i == 2) ? 6 : 5);
        end
      end
    end
    bus.inc_sw = 1'b0;
    cycle();
    checks++;
    if (bus.level !== 4'd6) begin
      failures++;
      $display("[TB] FAIL inc_hold_final got=%0d exp=6", bus.level);
    end
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 20; p++) begin
      for (int c = 0; c < 6; c++) begin
        bus.inc_sw = (p < 8)  && (c < 3);
        bus.dec_sw = (p >= 8) && (c < 3);
        cycle();
        checks++;
        if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {m_pwm, 4'(m_level), m_ps, m_seg}) begin
          failures++;
          $display("[TB] FAIL saturation p=%0d c=%0d got=%b exp=%b", p, c,
                   {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {m_pwm, 4'(m_level), m_ps, m_seg});
        end
      end
      if (p == 7) begin
        checks++;
        if (bus.level !== 4'd9) begin
          failures++;
          $display("[TB] FAIL sat_max got=%0d exp=9", bus.level);
        end
      end
    end
    for (int i = 0; i < 40; i++) cycle();
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({bus.pwm_out, bus.level} !== {1'b0, 4'd0}) begin
        failures++;
        $display("[TB] FAIL sat_zero i=%0d got=%b exp=%b", i, {bus.pwm_out, bus.level}, 5'b0);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 6; c++) begin
        bus.inc_sw = (c < 3);
        bus.dec_sw = (p >= 4) && (c < 3);
        cycle();
        checks++;
        if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {m_pwm, 4'(m_level), m_ps, m_seg}) begin
          failures++;
          $display("[TB] FAIL simultaneous p=%0d c=%0d got=%b exp=%b", p, c,
                   {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {m_pwm, 4'(m_level), m_ps, m_seg});
        end
      end
    end
    checks++;
    if (bus.level !== 4'd4) begin
      failures++;
      $display("[TB] FAIL simultaneous_level got=%0d exp=4", bus.level);
    end
    bus.run_en = 1'b0;
    cycle();
    checks++;
    if (bus.level !== 4'd0) begin
      failures++;
      $display("[TB] FAIL stop_level got=%0d exp=0", bus.level);
    end
    for (int i = 0; i < 18; i++) begin
      bus.inc_sw = ((i % 6) < 3);
      cycle();
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start} !== 6'b0) begin
        failures++;
        $display("[TB] FAIL idle_ignore i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start}, 6'b0);
      end
    end
    bus.inc_sw = 1'b0;
  endtask

  task automatic test_seg();
    bus.run_en = 1'b1;
    for (int p = 0; p < 15; p++) begin
      for (int c = 0; c < 6; c++) begin
        bus.dec_sw = (p < 5)  && (c < 3);
        bus.inc_sw = (p >= 5) && (c < 3);
        cycle();
        checks++;
        if ({bus.level, bus.seg_n} !== {4'(m_level), m_seg}) begin
          failures++;
          $display("[TB] FAIL seg p=%0d c=%0d got=%b exp=%b", p, c,
                   {bus.level, bus.seg_n}, {4'(m_level), m_seg});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) bus.inc_sw = ~bus.inc_sw;
      if ($urandom_range(0, 4) == 0) bus.dec_sw = ~bus.dec_sw;
      if ($urandom_range(0, 299) == 0) bus.run_en = ~bus.run_en;
      cycle();
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {m_pwm, 4'(m_level), m_ps, m_seg}) begin
        failures++;
        $display("[TB] FAIL random i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {m_pwm, 4'(m_level), m_ps, m_seg});
      end
    end
    bus.inc_sw = 1'b0;
    bus.dec_sw = 1'b0;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    bus.run_en = 1'b1;
    for (int i = 0; i < 200 && !found; i++) begin
      cycle();
      if (m_run && m_pwm) found = 1'b1;
    end
    checks++;
    if (!found || bus.pwm_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_setup got=%b exp=1", bus.pwm_out);
    end
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({bus.pwm_out, bus.level, bus.period_start} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%b exp=%b", {bus.pwm_out, bus.level, bus.period_start}, 6'b0);
    end
    bus.run_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({bus.pwm_out, bus.level, bus.period_start, bus.seg_n} !== {1'b0, 4'd0, 1'b0, seg_of(0)}) begin
        failures++;
        $display("[TB] FAIL after_reset_idle i=%0d got=%b exp=%b", i,
                 {bus.pwm_out, bus.level, bus.period_start, bus.seg_n}, {1'b0, 4'd0, 1'b0, seg_of(0)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_inc_hold();
    test_saturation();
    test_simultaneous();
    test_seg();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
